// File: rtl/except_ctrl_pkg.sv
// Shared CP0 / exception definitions: register bit positions, exception codes,
// the exception vector and the except_ctrl state encoding.
package except_ctrl_pkg;

   // CP0 Status / Cause field positions
   localparam int unsigned STATUS_IE_BIT  = 0;
   localparam int unsigned STATUS_EXL_BIT = 1;
   localparam int unsigned IM_LSB         = 8;
   localparam int unsigned IM_MSB         = 15;

   // flags_i bit positions from the MEM stage
   localparam int unsigned FLAG_ADEL_FETCH = 0;
   localparam int unsigned FLAG_RI         = 1;
   localparam int unsigned FLAG_SYSCALL    = 2;
   localparam int unsigned FLAG_BREAK      = 3;
   localparam int unsigned FLAG_OV         = 4;
   localparam int unsigned FLAG_TRAP       = 5;
   localparam int unsigned FLAG_ERET       = 6;

   // Exception codes handed to CP0
   localparam logic [31:0] EXC_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
   localparam logic [31:0] EXC_ADES = 32'h0000_0005;
   localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_BP   = 32'h0000_0009;
   localparam logic [31:0] EXC_RI   = 32'h0000_000a;
   localparam logic [31:0] EXC_OV   = 32'h0000_000c;
   localparam logic [31:0] EXC_TR   = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } exc_state_e;

   typedef struct packed {
      logic [31:0] code;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] bad;
   } exc_rec_t;

   function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
      return status[STATUS_IE_BIT] && !status[STATUS_EXL_BIT] &&
             (|(cause[IM_MSB:IM_LSB] & status[IM_MSB:IM_LSB]));
   endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// MEM-stage / CP0 signal bundle for except_ctrl; the pipeline side is master,
// the exception controller is slave.
interface except_ctrl_if;
   logic        valid_i;
   logic        stall_i;
   logic [31:0] inst_addr_i;
   logic        in_delayslot_i;
   logic [6:0]  flags_i;
   logic        adel_data_i;
   logic        ades_i;
   logic [31:0] data_vaddr_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;

   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic [31:0] newpc_o;

   modport master (
      output valid_i, stall_i, inst_addr_i, in_delayslot_i, flags_i,
             adel_data_i, ades_i, data_vaddr_i, status_i, cause_i, epc_i,
      input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, newpc_o
   );

   modport slave (
      input  valid_i, stall_i, inst_addr_i, in_delayslot_i, flags_i,
             adel_data_i, ades_i, data_vaddr_i, status_i, cause_i, epc_i,
      output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, newpc_o
   );
endinterface

// File: rtl/except_ctrl_prio.sv
// except_prio: combinational exception priority encoder for the MEM stage.
// Trap detection (code 0xd) is only built when EXC_TRAP_EN is defined.
module except_prio
   import except_ctrl_pkg::*;
(
   input  logic        valid_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [6:0]  flags_i,
   input  logic        adel_data_i,
   input  logic        ades_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] data_vaddr_i,
   output logic        detect_o,
   output logic [31:0] code_o,
   output logic [31:0] bad_addr_o
);

   always_comb begin
      detect_o   = 1'b0;
      code_o     = '0;
      bad_addr_o = '0;
      if (valid_i) begin
         detect_o = 1'b1;
         if (int_pending(status_i, cause_i)) begin
            code_o = EXC_INT;
         end else if (flags_i[FLAG_ADEL_FETCH]) begin
            code_o     = EXC_ADEL;
            bad_addr_o = inst_addr_i;
         end else if (flags_i[FLAG_RI]) begin
            code_o = EXC_RI;
         end else if (flags_i[FLAG_OV]) begin
            code_o = EXC_OV;
`ifdef EXC_TRAP_EN
         end else if (flags_i[FLAG_TRAP]) begin
            code_o = EXC_TR;
`endif
         end else if (flags_i[FLAG_SYSCALL]) begin
            code_o = EXC_SYS;
         end else if (flags_i[FLAG_BREAK]) begin
            code_o = EXC_BP;
         end else if (adel_data_i) begin
            code_o     = EXC_ADEL;
            bad_addr_o = data_vaddr_i;
         end else if (ades_i) begin
            code_o     = EXC_ADES;
            bad_addr_o = data_vaddr_i;
         end else if (flags_i[FLAG_ERET]) begin
            code_o = EXC_ERET;
         end else begin
            detect_o = 1'b0;
         end
      end
   end

   // Fields of Status/Cause that play no part in interrupt qualification
   logic unused_bits;
   assign unused_bits = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:16],
                          cause_i[7:0], flags_i[FLAG_TRAP]};

endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception controller (IDLE/HOLD/FLUSH). All outputs are
// registered. Build option: EXC_TRAP_EN enables trap exceptions (code 0xd).
module except_ctrl
   import except_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   except_ctrl_if.slave bus
);

   exc_state_e  state;
   exc_rec_t    cap;
   exc_rec_t    sel;
   logic        det;
   logic [31:0] det_code;
   logic [31:0] det_bad;
   logic        go_flush;

   logic [31:0] excepttype_q;
   logic [31:0] cur_pc_q;
   logic        ds_q;
   logic [31:0] bad_addr_q;
   logic        flush_q;
   logic [31:0] newpc_q;

   except_prio u_prio (
      .valid_i     (bus.valid_i),
      .status_i    (bus.status_i),
      .cause_i     (bus.cause_i),
      .flags_i     (bus.flags_i),
      .adel_data_i (bus.adel_data_i),
      .ades_i      (bus.ades_i),
      .inst_addr_i (bus.inst_addr_i),
      .data_vaddr_i(bus.data_vaddr_i),
      .detect_o    (det),
      .code_o      (det_code),
      .bad_addr_o  (det_bad)
   );

   // In IDLE the record comes straight from detection so a non-stalled
   // exception can reach FLUSH in one cycle; otherwise the captured copy is used.
   always_comb begin
      sel = cap;
      if (state == ST_IDLE) begin
         sel.code = det_code;
         sel.pc   = bus.inst_addr_i;
         sel.ds   = bus.in_delayslot_i;
         sel.bad  = det_bad;
      end
      go_flush = !bus.stall_i &&
                 ((state == ST_IDLE && det) || state == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         cap          <= '0;
         excepttype_q <= '0;
         cur_pc_q     <= '0;
         ds_q         <= 1'b0;
         bad_addr_q   <= '0;
         flush_q      <= 1'b0;
         newpc_q      <= '0;
      end else begin
         excepttype_q <= '0;
         cur_pc_q     <= '0;
         ds_q         <= 1'b0;
         bad_addr_q   <= '0;
         flush_q      <= 1'b0;
         newpc_q      <= '0;

         unique case (state)
            ST_IDLE: begin
               if (det) begin
                  cap   <= sel;
                  state <= bus.stall_i ? ST_HOLD : ST_FLUSH;
               end
            end
            ST_HOLD: begin
               if (!bus.stall_i) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // Output registers load on the edge entering FLUSH so they are valid
         // for exactly the FLUSH cycle.
         if (go_flush) begin
            excepttype_q <= sel.code;
            cur_pc_q     <= sel.pc;
            ds_q         <= sel.ds;
            bad_addr_q   <= sel.bad;
            flush_q      <= 1'b1;
            newpc_q      <= (sel.code == EXC_ERET) ? bus.epc_i : EXC_VECTOR;
         end
      end
   end

   assign bus.excepttype_o        = excepttype_q;
   assign bus.current_inst_addr_o = cur_pc_q;
   assign bus.is_in_delayslot_o   = ds_q;
   assign bus.bad_addr_o          = bad_addr_q;
   assign bus.flush_o             = flush_q;
   assign bus.newpc_o             = newpc_q;

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst (active-low, synchronous).
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-low reset
- valid_i  in  1  MEM stage holds a real instruction
- stall_i  in  1  MEM stage stalled (cache miss)
- inst_addr_i  in  32  MEM-stage PC
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- flags_i  in  7  [0]fetch AdEL, [1]RI, [2]syscall, [3]break, [4]overflow, [5]trap, [6]eret
- adel_data_i  in  1  load address error
- ades_i  in  1  store address error
- data_vaddr_i  in  32  load/store virtual address
- status_i, cause_i, epc_i  in  32 each  current CP0 values
- excepttype_o  out  32  code to CP0
- current_inst_addr_o  out  32  faulting PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr value to CP0
- flush_o  out  1  pipeline flush pulse
- newpc_o  out  32  redirect PC

Function
REQ-003 Interrupt pending SHALL be: status_i[0]=1 and status_i[1]=0 and (cause_i[15:8] & status_i[15:8]) != 0.
REQ-004 Detection SHALL occur only when valid_i=1; priority, highest first: interrupt 0x1, fetch AdEL 0x4, RI 0xa, overflow 0xc, trap 0xd, syscall 0x8, break 0x9, data AdEL 0x4, AdES 0x5, eret 0xe.
REQ-005 bad_addr SHALL be inst_addr_i for fetch AdEL, data_vaddr_i for data AdEL/AdES, 0 otherwise.
REQ-006 FSM states SHALL be IDLE, HOLD, FLUSH.
REQ-007 IDLE: detect and stall_i=0 -> FLUSH; detect and stall_i=1 -> HOLD; otherwise stay.
REQ-008 On leaving IDLE, code, PC, delay-slot flag and bad_addr SHALL be captured; HOLD ignores further detections (first captured wins).
REQ-009 HOLD -> FLUSH on the first cycle with stall_i=0.
REQ-010 FLUSH SHALL last exactly one cycle, then go to IDLE; detection is suppressed during FLUSH.
REQ-011 In FLUSH only, outputs SHALL be: excepttype_o = captured code, flush_o = 1, plus captured PC, delay-slot flag and bad_addr. In all other states excepttype_o=0 and flush_o=0.
REQ-012 newpc_o SHALL be epc_i (sampled in FLUSH) for 0xe, else 32'hBFC00380; newpc_o=0 outside FLUSH.
REQ-013 Latency: detection with stall_i=0 in cycle N -> flush_o=1 in cycle N+1.
REQ-014 Every output SHALL be registered or decoded from state only; no combinational path from flags_i to outputs.

Reset
REQ-015 When rst=0 at a clock edge: state=IDLE and all outputs and captured registers = 0, including mid-HOLD or mid-FLUSH.

Configuration
REQ-016 Macro EXC_TRAP_EN: when defined, flags_i[5] raises 0x0000000d. When undefined, flags_i[5] is ignored and code 0xd is never produced.

Structure
REQ-017 Exception code constants, the vector address 32'hBFC00380, and the state encoding SHALL live in the shared defines header alongside the existing CP0 definitions.
REQ-018 Priority encoding SHALL be one sub-module, except_prio (combinational), instantiated once.

Verification
REQ-019 status=0x0000FF01, cause[10]=1, valid=1, stall=0 -> next cycle: excepttype=0x1, flush=1, newpc=0xBFC00380, current_inst_addr=inst_addr.
REQ-020 flags=RI|syscall, inst_addr=0x80001000, in_delayslot=1 -> excepttype=0xa, is_in_delayslot=1, exactly one flush cycle.
REQ-021 ades=1, data_vaddr=0x80002003, stall high for 3 cycles -> HOLD for 3 cycles, then one FLUSH with 0x5 and bad_addr=0x80002003; a syscall arriving during HOLD is ignored.
REQ-022 eret with epc=0x80000100 -> excepttype=0xe, newpc=0x80000100.
REQ-023 rst=0 asserted during HOLD -> next cycle all outputs 0 and no FLUSH afterwards; with EXC_TRAP_EN undefined, a flags=trap-only input produces no flush.
